booth_radix4_multiplier: RTL and testbench

//  Sequential radix-4 Booth multiplier: a parametrised successor to the fixed 6-bit radix-2 unit.

---
 rtl/booth_radix4_multiplier_pkg.sv | 32 +++
 rtl/booth_radix4_multiplier_encoder.sv | 46 ++++
 rtl/booth_radix4_multiplier.sv | 105 ++++++++++
 tb/tb_booth_radix4_multiplier.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_radix4_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth multiplier.
//  - state_t : control FSM encoding (IDLE / CALC / DONE)
//  - digit_t : Booth digit code selected from a multiplier triplet
//  - booth_w2 / booth_n : derived widths for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  // Operands are widened by two bits so that signed and unsigned operations
  // both take exactly the same number of radix-4 digits.
  function automatic int booth_w2(input int width);
    return width + 2;
  endfunction

  // Number of radix-4 digits (CALC cycles) for an extended operand.
  function automatic int booth_n(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_multiplier_encoder.sv
// Radix-4 Booth digit encoder and partial-product selector (combinational).
// Ports:
//  triplet : {q[i+1], q[i], q[i-1]} multiplier bits
//  m_ext   : multiplicand already extended to WIDTH+2 bits (signed view)
//  pp      : selected partial product in {0, +-M, +-2M}, WIDTH+3 bits
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic              [2:0]       triplet,
  input  logic signed       [WIDTH+1:0] m_ext,
  output logic signed       [WIDTH+2:0] pp
);

  localparam int AW = WIDTH + 3;

  digit_t               digit;
  logic signed [AW-1:0] m_aw;

  // One extra sign bit so that 2*M of the extended operand cannot overflow.
  assign m_aw = {m_ext[WIDTH+1], m_ext};

  always_comb begin
    digit = ZERO;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    pp = '0;
    case (digit)
      POS1:    pp = m_aw;
      POS2:    pp = m_aw <<< 1;
      NEG1:    pp = -m_aw;
      NEG2:    pp = -(m_aw <<< 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Ports:
//  clk, reset     : clock, synchronous active-high reset
//  load / ready   : operand handshake (accept on load && ready)
//  is_signed      : 1 = two's complement operands, 0 = unsigned
//  M, Q           : multiplicand / multiplier, WIDTH bits
//  P              : registered 2*WIDTH-bit product, held while done=1
//  done / ack     : result handshake (retire on done && ack)
module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  output logic                 ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   P,
  output logic                 done,
  input  logic                 ack
);

  localparam int W2 = booth_w2(WIDTH);
  localparam int N  = booth_n(WIDTH);
  localparam int AW = WIDTH + 3;
  localparam int CW = $clog2(N + 1);

  state_t               state;
  logic signed [AW-1:0] acc;
  logic        [W2-1:0] qr;
  logic                 qm1;
  logic signed [W2-1:0] mr;
  logic        [CW-1:0] cnt;

  logic signed [AW-1:0]    pp;
  logic signed [AW-1:0]    sum;
  logic        [AW+W2-1:0] shifted;

  booth_r4_encoder #(
    .WIDTH (WIDTH)
  ) u_enc (
    .triplet ({qr[1], qr[0], qm1}),
    .m_ext   (mr),
    .pp      (pp)
  );

  assign sum = acc + pp;

  // Arithmetic shift of {acc, q} right by two: acc's sign fills the top,
  // the two bits leaving acc become the top product bits held in q.
  assign shifted = {sum[AW-1], sum[AW-1], sum, qr[W2-1:2]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      P     <= '0;
      acc   <= '0;
      qr    <= '0;
      qm1   <= 1'b0;
      mr    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            mr    <= is_signed ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
            qr    <= is_signed ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= shifted[AW+W2-1:W2];
          qr  <= shifted[W2-1:0];
          qm1 <= qr[1];
          cnt <= cnt + 1'b1;
          // After the last digit {acc, q} holds the exact product; its low
          // 2*WIDTH bits are the result in both signed and unsigned modes.
          if (cnt == CW'(N - 1)) begin
            P     <= shifted[2*WIDTH-1:0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (ack) begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench: a WIDTH=6 instance for directed/handshake scenarios and a
// WIDTH=16 instance for a randomized signed/unsigned sweep.
module tb_booth_radix4_multiplier;

  localparam int N6  = 4;
  localparam int N16 = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    longint p;
    int     acc_cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // WIDTH=6 instance
  logic        a_reset = 1'b1, a_load = 1'b0, a_sgn = 1'b0, a_ack = 1'b0;
  logic [5:0]  a_M = '0, a_Q = '0;
  logic        a_ready, a_done;
  logic [11:0] a_P;

  booth_radix4_multiplier #(.WIDTH(6)) dut_a (
    .clk(clk), .reset(a_reset), .load(a_load), .ready(a_ready),
    .is_signed(a_sgn), .M(a_M), .Q(a_Q), .P(a_P), .done(a_done), .ack(a_ack)
  );

  // WIDTH=16 instance
  logic        b_reset = 1'b1, b_load = 1'b0, b_sgn = 1'b0, b_ack = 1'b0;
  logic [15:0] b_M = '0, b_Q = '0;
  logic        b_ready, b_done;
  logic [31:0] b_P;

  booth_radix4_multiplier #(.WIDTH(16)) dut_b (
    .clk(clk), .reset(b_reset), .load(b_load), .ready(b_ready),
    .is_signed(b_sgn), .M(b_M), .Q(b_Q), .P(b_P), .done(b_done), .ack(b_ack)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact mathematical product, reduced to 2*w bits.
  function automatic longint ref_prod(input longint m, input longint q,
                                      input bit s, input int w);
    longint mask;
    mask = (longint'(1) << (2 * w)) - 1;
    if (s && m[w-1]) m = m - (longint'(1) << w);
    if (s && q[w-1]) q = q - (longint'(1) << w);
    return (m * q) & mask;
  endfunction

  // ---------------- monitors ----------------
  logic        a_done_prev = 1'b0;
  logic [11:0] a_held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (a_done) begin
      if (!a_done_prev) begin
        if (qa.size() == 0) check("a_unexpected_done", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_product", a_P, e.p);
          check("a_latency", cyc - e.acc_cyc, N6);
        end
        a_held = a_P;
      end else begin
        check("a_hold_P", a_P, a_held);
        check("a_hold_ready", a_ready, 0);
      end
    end
    a_done_prev = a_done;
  end

  logic        b_done_prev = 1'b0;
  logic [31:0] b_held = '0;
  always @(negedge clk) begin
    exp_t e;
    if (b_done) begin
      if (!b_done_prev) begin
        if (qb.size() == 0) check("b_unexpected_done", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_product", b_P, e.p);
          check("b_latency", cyc - e.acc_cyc, N16);
        end
        b_held = b_P;
      end else begin
        check("b_hold_P", b_P, b_held);
        check("b_hold_ready", b_ready, 0);
      end
    end
    b_done_prev = b_done;
  end

  // Random back-pressure on the wide instance.
  always @(negedge clk) b_ack = ($urandom_range(0, 3) != 0);

  // ---------------- drivers ----------------
  task automatic issue_a(input logic [5:0] m, input logic [5:0] q,
                         input logic s, input longint expv);
    int t;
    t = 0;
    while (!a_ready && t < 50) begin @(negedge clk); t++; end
    if (!a_ready) begin check("a_ready_timeout", 0, 1); return; end
    a_M = m; a_Q = q; a_sgn = s; a_load = 1'b1;
    qa.push_back('{expv, cyc + 1});
    @(negedge clk);
    a_load = 1'b0;
    a_M = 6'($urandom); a_Q = 6'($urandom); a_sgn = 1'($urandom);
  endtask

  task automatic finish_a(input int hold, input logic ld);
    int t;
    t = 0;
    while (!a_done && t < 20) begin @(negedge clk); t++; end
    if (!a_done) begin check("a_done_timeout", 0, 1); return; end
    repeat (hold) begin a_load = ld; @(negedge clk); end
    a_ack = 1'b1; a_load = ld;
    @(negedge clk);
    a_ack = 1'b0; a_load = 1'b0;
    check("a_ready_after_ack", a_ready, 1);
    check("a_done_after_ack", a_done, 0);
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while (((which == 0) ? qa.size() : qb.size()) > 0 && t < 200) begin
      @(negedge clk); t++;
    end
    check("drain", (which == 0) ? qa.size() : qb.size(), 0);
  endtask

  initial begin
    int   prev, n, t;
    logic [5:0] m6, q6;
    logic s6;
    logic [15:0] m16, q16;
    logic s16;

    repeat (2) @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0;
    check("reset_ready", a_ready, 1);
    check("reset_done", a_done, 0);
    check("reset_P", a_P, 0);
    check("reset_b_ready", b_ready, 1);

    // Directed products (expected values are hand-derived constants)
    issue_a(6'b101010, 6'b101111, 1'b1, 64'h176); finish_a(0, 1'b0);
    issue_a(6'b101010, 6'b101111, 1'b0, 64'h7B6); finish_a(0, 1'b0);
    issue_a(6'd1,      6'd7,      1'b0, 64'h007); finish_a(0, 1'b0);
    issue_a(6'd63,     6'd63,     1'b0, 64'hF81); finish_a(0, 1'b0);
    issue_a(6'b100000, 6'b100000, 1'b1, 64'h400); finish_a(0, 1'b0);
    issue_a(6'b100000, 6'b011111, 1'b1, 64'hC20); finish_a(0, 1'b0);
    issue_a(6'd0,      6'd45,     1'b1, 64'h000); finish_a(0, 1'b0);
    issue_a(6'd1,      6'b111111, 1'b1, 64'hFFF); finish_a(0, 1'b0);

    // Back-pressure: ack held low 10 cycles with load asserted throughout,
    // including the ack cycle itself.
    issue_a(6'd19, 6'd37, 1'b0, 64'h2BF); finish_a(10, 1'b1);

    // Reset two cycles after accept aborts the operation.
    issue_a(6'd9, 6'd9, 1'b0, 64'h051);
    @(negedge clk);
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0;
    qa.delete();
    check("abort_ready", a_ready, 1);
    check("abort_done", a_done, 0);
    check("abort_P", a_P, 0);
    issue_a(6'd5, 6'b111101, 1'b1, 64'hFF1); finish_a(0, 1'b0);

    // Back-to-back with load held and ack tied high.
    a_ack = 1'b1; a_load = 1'b1; prev = -1; n = 0; t = 0;
    while (n < 6 && t < 200) begin
      if (a_ready) begin
        m6 = 6'($urandom); q6 = 6'($urandom); s6 = 1'($urandom);
        a_M = m6; a_Q = q6; a_sgn = s6;
        qa.push_back('{ref_prod(longint'(m6), longint'(q6), s6, 6), cyc + 1});
        if (prev >= 0) check("a_b2b_spacing", cyc + 1 - prev, N6 + 2);
        prev = cyc + 1;
        n++;
      end
      @(negedge clk);
      t++;
    end
    a_load = 1'b0;
    check("a_b2b_count", n, 6);
    drain(0);
    a_ack = 1'b0;

    // Random unsigned/signed sweep on the 16-bit instance.
    for (int k = 0; k < 1000; k++) begin
      t = 0;
      while (!b_ready && t < 60) begin @(negedge clk); t++; end
      if (!b_ready) begin check("b_ready_timeout", 0, 1); break; end
      m16 = 16'($urandom); q16 = 16'($urandom); s16 = 1'($urandom);
      if (k == 0) begin m16 = 16'h8000; q16 = 16'h8000; s16 = 1'b1; end
      if (k == 1) begin m16 = 16'hFFFF; q16 = 16'hFFFF; s16 = 1'b0; end
      b_M = m16; b_Q = q16; b_sgn = s16; b_load = 1'b1;
      qb.push_back('{ref_prod(longint'(m16), longint'(q16), s16, 16), cyc + 1});
      @(negedge clk);
      b_load = 1'b0;
      b_M = 16'($urandom); b_Q = 16'($urandom); b_sgn = 1'($urandom);
    end
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
